hdc_bundler_seq: RTL and testbench
==================================

# hdc_bundler_seq

Streaming, parametrised majority bundler for the HDC datapath. It accepts hypervectors one per cycle over a valid/ready handshake and accumulates per-dimension ones-counts. When a bundle closes, it binarises the counts to a majority hypervector, with a selectable tie policy, and presents the result over an output handshake. It sits between the channel encoders and the associative memory. It replaces the all-at-once combinational bundling, so bundle size is a runtime property rather than a fixed port array.

## Interface
- DIMENSIONS, 10000, hypervector width in bits
- MAX_HVS, 32, maximum hypervectors per bundle; sets counter width CNT_W = $clog2(MAX_HVS+1)
- TIE_MODE, 0, tie policy: 0 = LFSR bit, 1 = force 0, 2 = force 1
- LFSR_SEED, 16'b1001010010110101, tie LFSR reset value; all-zero seed is replaced by 16'h0001
- clk  in  1  single clock, rising edge
- nrst  in  1  asynchronous, active-low reset
- in_valid  in  1  in_hv/in_last valid
- in_ready  out  1  block can accept a beat
- in_hv  in  DIMENSIONS  hypervector to add to the current bundle
- in_last  in  1  beat is the final member of the bundle
- out_valid  out  1  hvout/out_count valid
- out_ready  in  1  consumer accepts result
- hvout  out  DIMENSIONS  bundled (majority) hypervector
- out_count  out  CNT_W  number of hypervectors in the emitted bundle
- err_overflow  out  1  sticky flag: a bundle was force-closed at MAX_HVS
- clear  in  1  synchronous abort: drops the partial bundle and returns to ACC

## Operation
- States: ACC, BIN, OUT.
- ACC
  - in_ready=1.
  - Each accepted beat increments ones[i] for every set in_hv[i], and increments n.
  - Accepting with in_last=1 goes to BIN.
  - Accepting the beat that makes n==MAX_HVS without in_last also goes to BIN and sets err_overflow.
- BIN
  - in_ready=0.
  - Per dimension: hvout[i]=1 if 2*ones[i] > n; 0 if 2*ones[i] < n; tie bit if equal.
  - Tie bit is lfsr_q[i mod 16] (TIE_MODE 0), 0 (mode 1) or 1 (mode 2).
  - out_count=n.
  - LFSR advances one step on exit from BIN, i.e. once per bundle.
  - Go to OUT.
- OUT
  - in_ready=0, out_valid=1.
  - hvout and out_count are held stable until out_ready=1.
  - On the handshake: ones[] and n clear to 0, return to ACC.
- Odd n never ties; n=1 gives hvout = in_hv.
- Comparisons use CNT_W+1 bits so that 2*ones[i] cannot overflow.
- clear
  - In ACC or BIN: zeroes ones[] and n, next state ACC, no output produced.
  - In OUT: ignored; the result is still delivered.
  - clear has priority over a beat accepted in the same cycle, and that beat is dropped.
- err_overflow is cleared only by reset.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts left, feedback into bit 0.

## Timing
- Reset values:
  - state=ACC, in_ready=1, out_valid=0, hvout=0, out_count=0, err_overflow=0.
  - ones[] and n = 0; lfsr_q = LFSR_SEED.
- Last beat accepted on edge k gives BIN during cycle k..k+1, with hvout registered on edge k+1.
- out_valid is high from edge k+1 onward; latency is 1 cycle from the last-beat acceptance edge.
- Throughput: one bundle of n beats every n+2 cycles when out_ready is held at 1.
- Reset asserted mid-bundle or during OUT discards everything immediately, asynchronously.
- in_ready depends only on state and is never combinationally dependent on in_valid or out_ready.

## Structure
- Shared hdc_pkg holds:
  - the state enum type (ACC/BIN/OUT);
  - TIE_MODE encodings as localparams (TIE_LFSR, TIE_ZERO, TIE_ONE);
  - the default LFSR seed and tap constant.
- One sub-module, hdc_tie_lfsr:
  - 16-bit LFSR with SEED parameter, advance enable and seed-zero guard;
  - instantiated only when TIE_MODE==0.
- Counter array and binarisation stay in the top module, as a generate loop over DIMENSIONS.

## Test plan
Bench runs with DIMENSIONS=8, MAX_HVS=4, TIE_MODE=1 unless stated.
- Bundle 8'hF0, 8'hCC, 8'hAA (last) -> hvout=8'hE8, out_count=3, out_valid one cycle after last acceptance.
- Bundle 8'hFF, 8'h0F (last), TIE_MODE=1 -> hvout=8'h0F; same with TIE_MODE=2 -> 8'hFF.
- TIE_MODE=0, two consecutive ties-everywhere bundles (8'hFF, 8'h00) -> hvout equals LFSR_SEED[7:0], then the next LFSR state's low byte.
- Four beats 8'h01, none with in_last -> forced close after the 4th beat, hvout=8'h01, out_count=4, err_overflow=1 and stays 1 for the next bundle.
- out_ready held low 5 cycles in OUT -> hvout and out_count stable, in_ready=0 throughout; one cycle after the handshake, a new bundle is accepted.
- Two beats then clear with in_valid=1 -> no output, next bundle 8'h3C (last) yields hvout=8'h3C, out_count=1; nrst pulse mid-bundle behaves likewise.

Source files
------------

// File: rtl/hdc_pkg.sv
// Shared types and constants for the HDC bundling datapath.
package hdc_pkg;

    typedef enum logic [1:0] {
        ACC = 2'd0,
        BIN = 2'd1,
        OUT = 2'd2
    } hdc_state_e;

    localparam int TIE_LFSR = 0;
    localparam int TIE_ZERO = 1;
    localparam int TIE_ONE  = 2;

    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'b1001010010110101;
    // Taps x^16 + x^14 + x^13 + x^11 map to bits 15, 13, 12, 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/hdc_tie_lfsr.sv
// 16-bit Fibonacci LFSR supplying tie-break bits; steps once per advance pulse.
module hdc_tie_lfsr
    import hdc_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        advance,
    output logic [15:0] q
);

    // An all-zero state would lock up the register forever.
    localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            q <= SEED_SAFE;
        end else if (advance) begin
            q <= {q[14:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/hdc_bundler_seq.sv
// Streaming majority bundler: accumulates per-dimension ones-counts over a
// runtime-sized bundle, then emits the binarised majority hypervector.
module hdc_bundler_seq
    import hdc_pkg::*;
#(
    parameter int          DIMENSIONS = 10000,
    parameter int          MAX_HVS    = 32,
    parameter int          TIE_MODE   = TIE_LFSR,
    parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT,
    localparam int         CNT_W      = $clog2(MAX_HVS + 1)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIMENSIONS-1:0] in_hv,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIMENSIONS-1:0] hvout,
    output logic [CNT_W-1:0]      out_count,
    output logic                  err_overflow,
    input  logic                  clear,
    output hdc_state_e            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // valid never waits on ready, and in_ready/out_valid depend on state only.

    hdc_state_e            state_q, state_d;
    logic [CNT_W-1:0]      n_q;
    logic [CNT_W-1:0]      ones_q [DIMENSIONS];
    logic [DIMENSIONS-1:0] maj;
    logic [15:0]           lfsr_q;
    logic                  accept, cnt_inc, cnt_clr, n_at_limit;
    logic                  load_out, lfsr_adv, set_ovf;

    assign in_ready   = (state_q == ACC);
    assign out_valid  = (state_q == OUT);
    assign dbg_state  = state_q;
    assign accept     = in_valid && in_ready;
    assign n_at_limit = (n_q == CNT_W'(MAX_HVS - 1));
    // clear beats a same-cycle beat; it is ignored only while a result is offered.
    assign cnt_inc    = accept && !clear;
    assign cnt_clr    = (clear && (state_q != OUT)) || (out_valid && out_ready);

    always_comb begin
        state_d  = state_q;
        load_out = 1'b0;
        lfsr_adv = 1'b0;
        set_ovf  = 1'b0;
        case (state_q)
            ACC: begin
                if (cnt_inc && (in_last || n_at_limit)) begin
                    state_d = BIN;
                    set_ovf = !in_last;
                end
            end
            BIN: begin
                lfsr_adv = 1'b1;
                if (clear) begin
                    state_d = ACC;
                end else begin
                    load_out = 1'b1;
                    state_d  = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ACC;
            n_q          <= '0;
            hvout        <= '0;
            out_count    <= '0;
            err_overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cnt_clr) begin
                n_q <= '0;
            end else if (cnt_inc) begin
                n_q <= n_q + CNT_W'(1);
            end
            if (load_out) begin
                hvout     <= maj;
                out_count <= n_q;
            end
            if (set_ovf) begin
                err_overflow <= 1'b1;
            end
        end
    end

    if (TIE_MODE == TIE_LFSR) begin : g_lfsr
        hdc_tie_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
            .clk     (clk),
            .nrst    (nrst),
            .advance (lfsr_adv),
            .q       (lfsr_q)
        );
    end else begin : g_no_lfsr
        assign lfsr_q = '0;
    end

    for (genvar i = 0; i < DIMENSIONS; i++) begin : g_dim
        // One extra bit so doubling a full counter cannot wrap.
        logic [CNT_W:0] twice_ones;
        logic [CNT_W:0] n_ext;
        logic           tie;

        assign twice_ones = {ones_q[i], 1'b0};
        assign n_ext      = {1'b0, n_q};

        if (TIE_MODE == TIE_ZERO) begin : g_tie_zero
            assign tie = 1'b0;
        end else if (TIE_MODE == TIE_ONE) begin : g_tie_one
            assign tie = 1'b1;
        end else begin : g_tie_lfsr
            assign tie = lfsr_q[i % 16];
        end

        assign maj[i] = (twice_ones > n_ext) ? 1'b1 :
                        (twice_ones < n_ext) ? 1'b0 : tie;

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                ones_q[i] <= '0;
            end else if (cnt_clr) begin
                ones_q[i] <= '0;
            end else if (cnt_inc) begin
                ones_q[i] <= ones_q[i] + CNT_W'(in_hv[i]);
            end
        end
    end

endmodule

// File: tb/tb_hdc_bundler_seq.sv
// Bench for hdc_bundler_seq: three instances (tie zero / one / LFSR) share one
// input stream and are scored against a popcount-based majority model.
module tb_hdc_bundler_seq;
    import hdc_pkg::*;

    localparam int          D    = 8;
    localparam int          M    = 4;
    localparam int          CW   = $clog2(M + 1);
    localparam logic [15:0] SEED = 16'b1001010010110101;

    // ---------------- clock / reset / DUTs ----------------
    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b0;
    logic         clear = 1'b0;
    logic [D-1:0] in_hv = '0;

    // index 0: tie->0, 1: tie->1, 2: tie from LFSR
    logic [2:0]    in_ready, out_valid, err;
    logic [D-1:0]  hv  [3];
    logic [CW-1:0] cnt [3];
    hdc_state_e    st  [3];

    always #5 clk = ~clk;

    hdc_bundler_seq #(.DIMENSIONS(D), .MAX_HVS(M), .TIE_MODE(TIE_ZERO), .LFSR_SEED(SEED)) u_dut_zero (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_hv(in_hv),
        .in_last(in_last), .out_valid(out_valid[0]), .out_ready(out_ready), .hvout(hv[0]),
        .out_count(cnt[0]), .err_overflow(err[0]), .clear(clear), .dbg_state(st[0]));

    hdc_bundler_seq #(.DIMENSIONS(D), .MAX_HVS(M), .TIE_MODE(TIE_ONE), .LFSR_SEED(SEED)) u_dut_one (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready[1]), .in_hv(in_hv),
        .in_last(in_last), .out_valid(out_valid[1]), .out_ready(out_ready), .hvout(hv[1]),
        .out_count(cnt[1]), .err_overflow(err[1]), .clear(clear), .dbg_state(st[1]));

    hdc_bundler_seq #(.DIMENSIONS(D), .MAX_HVS(M), .TIE_MODE(TIE_LFSR), .LFSR_SEED(SEED)) u_dut_lfsr (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready[2]), .in_hv(in_hv),
        .in_last(in_last), .out_valid(out_valid[2]), .out_ready(out_ready), .hvout(hv[2]),
        .out_count(cnt[2]), .err_overflow(err[2]), .clear(clear), .dbg_state(st[2]));

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [D-1:0] model_beats [$];
    logic [15:0]  model_lfsr = SEED;
    logic         model_ovf  = 1'b0;
    logic [D-1:0] exp_q      [$];
    logic [D-1:0] exp_one_q  [$];
    logic [D-1:0] exp_lfsr_q [$];
    int           exp_cnt_q  [$];

    logic [D-1:0] stim_q [$];
    logic [D-1:0] obs_hv [3];
    int           obs_cnt;
    logic         obs_err;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        // x^k of the polynomial is state bit k-1
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // tie_kind: 0 -> zero, 1 -> one, 2 -> LFSR bit
    function automatic logic [D-1:0] majority(input int tie_kind);
        logic [D-1:0] r;
        int n;
        int ones;
        n = model_beats.size();
        for (int b = 0; b < D; b++) begin
            ones = 0;
            foreach (model_beats[k]) ones += int'(model_beats[k][b]);
            if (2 * ones > n)      r[b] = 1'b1;
            else if (2 * ones < n) r[b] = 1'b0;
            else if (tie_kind == 0) r[b] = 1'b0;
            else if (tie_kind == 1) r[b] = 1'b1;
            else                    r[b] = model_lfsr[b % 16];
        end
        return r;
    endfunction

    task automatic model_close();
        exp_q.push_back(majority(0));
        exp_one_q.push_back(majority(1));
        exp_lfsr_q.push_back(majority(2));
        exp_cnt_q.push_back(model_beats.size());
        model_lfsr = lfsr_next(model_lfsr);
        model_beats.delete();
    endtask

    // ---------------- driver tasks (enter and leave at a falling edge) ----------------
    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send_beat(input logic [D-1:0] v, input logic last);
        check("beat_in_ready", 32'(in_ready[0]), 32'd1);
        in_valid = 1'b1;
        in_hv    = v;
        in_last  = last;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_hv    = D'($urandom);
        model_beats.push_back(v);
    endtask

    task automatic collect_result(input int hold);
        int           waited;
        logic [D-1:0] h0;
        logic [CW-1:0] c0;
        int           ec;
        check("bin_no_valid", 32'(out_valid[0]), 32'd0);
        check("bin_in_ready", 32'(in_ready[0]), 32'd0);
        waited = 0;
        while (out_valid[0] !== 1'b1 && waited < 4) begin
            idle(1);
            waited++;
        end
        check("out_latency", 32'(waited), 32'd1);
        check("out_valid_lfsr", 32'(out_valid[2]), 32'd1);
        ec = exp_cnt_q.pop_front();
        check("hvout_zero", 32'(hv[0]), 32'(exp_q.pop_front()));
        check("hvout_one", 32'(hv[1]), 32'(exp_one_q.pop_front()));
        check("hvout_lfsr", 32'(hv[2]), 32'(exp_lfsr_q.pop_front()));
        check("out_count", 32'(cnt[0]), 32'(ec));
        check("out_count_lfsr", 32'(cnt[2]), 32'(ec));
        check("err_overflow", 32'(err[0]), 32'(model_ovf));
        for (int i = 0; i < 3; i++) obs_hv[i] = hv[i];
        obs_cnt = int'(cnt[0]);
        obs_err = err[0];
        h0 = hv[0];
        c0 = cnt[0];
        for (int h = 0; h < hold; h++) begin
            idle(1);
            check("hold_valid", 32'(out_valid[0]), 32'd1);
            check("hold_hvout", 32'(hv[0]), 32'(h0));
            check("hold_count", 32'(cnt[0]), 32'(c0));
            check("hold_in_ready", 32'(in_ready[0]), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_valid", 32'(out_valid[0]), 32'd0);
        check("post_hs_ready", 32'(in_ready[0]), 32'd1);
    endtask

    task automatic play_bundle(input bit use_last, input int hold, input bit gaps);
        int n;
        n = stim_q.size();
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle(1);
            send_beat(stim_q[i], use_last && (i == n - 1));
        end
        if (!use_last) model_ovf = 1'b1;
        model_close();
        stim_q.delete();
        collect_result(hold);
    endtask

    task automatic abort_acc();
        foreach (stim_q[i]) send_beat(stim_q[i], 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_hv    = D'($urandom);
        in_last  = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_beats.delete();
        stim_q.delete();
        check("clr_acc_no_valid", 32'(out_valid[0]), 32'd0);
        check("clr_acc_in_ready", 32'(in_ready[0]), 32'd1);
        idle(1);
        check("clr_acc_still_idle", 32'(out_valid[0]), 32'd0);
    endtask

    task automatic abort_bin();
        int n;
        n = stim_q.size();
        for (int i = 0; i < n; i++) send_beat(stim_q[i], i == n - 1);
        check("clr_bin_state", 32'(st[0]), 32'(BIN));
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        model_beats.delete();
        stim_q.delete();
        check("clr_bin_in_ready", 32'(in_ready[0]), 32'd1);
        for (int i = 0; i < 2; i++) begin
            check("clr_bin_no_valid", 32'(out_valid[0]), 32'd0);
            idle(1);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", 32'(in_ready[i]), 32'd1);
            check("rst_out_valid", 32'(out_valid[i]), 32'd0);
            check("rst_hvout", 32'(hv[i]), 32'd0);
            check("rst_count", 32'(cnt[i]), 32'd0);
            check("rst_err", 32'(err[i]), 32'd0);
            check("rst_state", 32'(st[i]), 32'(ACC));
        end
        nrst = 1'b1;
        idle(1);

        stim_q = '{8'hF0, 8'hCC, 8'hAA};
        play_bundle(1'b1, 0, 1'b0);
        check("dir_e8_hv", 32'(obs_hv[0]), 32'h0E8);
        check("dir_e8_cnt", 32'(obs_cnt), 32'd3);

        stim_q = '{8'hFF, 8'h0F};
        play_bundle(1'b1, 0, 1'b0);
        check("dir_tie_zero", 32'(obs_hv[0]), 32'h00F);
        check("dir_tie_one", 32'(obs_hv[1]), 32'h0FF);

        stim_q = '{D'($urandom), D'($urandom)};
        play_bundle(1'b1, 5, 1'b0);

        stim_q = '{8'h5A, 8'hC3};
        abort_acc();
        stim_q = '{8'h3C};
        play_bundle(1'b1, 0, 1'b0);
        check("dir_clr_hv", 32'(obs_hv[0]), 32'h03C);
        check("dir_clr_hv_lfsr", 32'(obs_hv[2]), 32'h03C);
        check("dir_clr_cnt", 32'(obs_cnt), 32'd1);

        stim_q = '{8'h01, 8'h01, 8'h01, 8'h01};
        play_bundle(1'b0, 0, 1'b0);
        check("dir_ovf_hv", 32'(obs_hv[0]), 32'h001);
        check("dir_ovf_cnt", 32'(obs_cnt), 32'd4);
        check("dir_ovf_err", 32'(obs_err), 32'd1);
        stim_q = '{8'h55};
        play_bundle(1'b1, 0, 1'b0);
        check("dir_ovf_sticky", 32'(obs_err), 32'd1);

        stim_q = '{8'h81, 8'h7E};
        abort_bin();

        // asynchronous reset mid-bundle
        send_beat(8'hF0, 1'b0);
        send_beat(8'h0F, 1'b0);
        #2 nrst = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready[0]), 32'd1);
        check("arst_out_valid", 32'(out_valid[0]), 32'd0);
        check("arst_hvout", 32'(hv[0]), 32'd0);
        check("arst_count", 32'(cnt[0]), 32'd0);
        check("arst_err", 32'(err[0]), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        model_beats.delete();
        model_lfsr = SEED;
        model_ovf  = 1'b0;
        idle(1);

        stim_q = '{8'hFF, 8'h00};
        play_bundle(1'b1, 0, 1'b0);
        check("dir_lfsr_first", 32'(obs_hv[2]), 32'h0B5);
        check("dir_lfsr_tie0", 32'(obs_hv[0]), 32'h000);
        stim_q = '{8'hFF, 8'h00};
        play_bundle(1'b1, 0, 1'b0);
        check("dir_lfsr_second", 32'(obs_hv[2]), 32'h06B);

        stim_q = '{8'h3C};
        play_bundle(1'b1, 0, 1'b0);
        check("dir_rst_hv", 32'(obs_hv[0]), 32'h03C);
        check("dir_rst_cnt", 32'(obs_cnt), 32'd1);

        for (int t = 0; t < 40; t++) begin
            int  sz;
            bit  use_last;
            if ($urandom_range(0, 9) == 0) begin
                sz = $urandom_range(1, M - 1);
                for (int i = 0; i < sz; i++) stim_q.push_back(D'($urandom));
                abort_acc();
            end else begin
                sz = $urandom_range(1, M);
                use_last = (sz < M) || ($urandom_range(0, 1) == 1);
                for (int i = 0; i < sz; i++) stim_q.push_back(D'($urandom));
                play_bundle(use_last, $urandom_range(0, 2), 1'b1);
            end
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
